// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with a registered select/data output stage.
// One requesting lane is picked per load opportunity, starting the search at
// the rotating pointer. Its index and data word are registered, and the lane
// receives a same-cycle combinational acknowledge.
module rr_mux_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     data,
    output logic [N-1:0]           ack,
    output logic [$clog2(N)-1:0]   sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned SW = $clog2(N);

    logic [SW-1:0]    ptr_q, ptr_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             load;
    logic             grant_found;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SW:0]      cand;

    // Search lanes ptr, ptr+1, ... wrapping modulo N (not 2^SW).
    // The first requesting lane found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (SW+1)'(i);
            if (cand >= (SW+1)'(N)) begin
                cand = cand - (SW+1)'(N);
            end
            if (!grant_found && req[cand[SW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SW-1:0];
            end
        end
    end

    // Pick out the granted lane's data word.
    always_comb begin
        grant_data = '0;
        for (int unsigned l = 0; l < N; l++) begin
            if (grant_idx == SW'(l)) begin
                grant_data = data[l*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot acknowledge for a capture happening this cycle.
    // It is forced low during reset.
    always_comb begin
        load = !out_valid_q || out_ready;
        ack  = '0;
        for (int unsigned l = 0; l < N; l++) begin
            ack[l] = !rst && load && grant_found && (grant_idx == SW'(l));
        end
    end

    // Next-state logic for the pointer and the output register.
    always_comb begin
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load) begin
            if (grant_found) begin
                sel_d       = grant_idx;
                out_data_d  = grant_data;
                out_valid_d = 1'b1;
                ptr_d       = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            sel_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter.
// Two instances are used: N=4 and N=3, both with WIDTH=4.
// Only one instance is exercised at a time; the other is held in reset.
module tb_rr_mux_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4 = 1'b1, ordy4 = 1'b0, ov4;
    logic [3:0]  req4 = '0, ack4, od4;
    logic [15:0] data4 = '0;
    logic [1:0]  sel4;

    logic        rst3 = 1'b1, ordy3 = 1'b0, ov3;
    logic [2:0]  req3 = '0, ack3;
    logic [3:0]  od3;
    logic [11:0] data3 = '0;
    logic [1:0]  sel3;

    rr_mux_arbiter #(.N(4), .WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .req(req4), .data(data4), .ack(ack4),
        .sel(sel4), .out_data(od4), .out_valid(ov4), .out_ready(ordy4)
    );

    rr_mux_arbiter #(.N(3), .WIDTH(4)) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .data(data3), .ack(ack3),
        .sel(sel3), .out_data(od3), .out_valid(ov3), .out_ready(ordy3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state, indexed by instance (0: N=4, 1: N=3).
    int   m_ptr[2];
    int   m_sel[2];
    int   m_data[2];
    logic m_valid[2];
    logic [3:0] last_ack;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (N=%0d) at %0t: actual %0h required %0h",
                     name, (inst == 0) ? 4 : 3, $time, act, exp);
        end
    endtask

    // First requesting lane at or after ptr, taken in circular order; -1 if none.
    function automatic int model_grant(input int n, input int ptr, input logic [3:0] rq);
        for (int k = 0; k < n; k++) begin
            if (rq[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset(input int inst);
        m_ptr[inst]   = 0;
        m_sel[inst]   = 0;
        m_data[inst]  = 0;
        m_valid[inst] = 1'b0;
    endtask

    // One clock cycle on the selected instance.
    // The combinational ack is checked before the edge.
    // The registered outputs are checked just after the edge.
    task automatic cyc(input int inst, input logic r, input logic [3:0] rq,
                       input logic [15:0] d, input logic o);
        int n;
        int g;
        logic load;
        logic [3:0] eack;
        n = (inst == 0) ? 4 : 3;
        if (inst == 0) begin
            rst4 = r; req4 = rq; data4 = d; ordy4 = o;
        end else begin
            rst3 = r; req3 = rq[2:0]; data3 = d[11:0]; ordy3 = o;
            rq[3] = 1'b0;
        end
        load = !m_valid[inst] || o;
        g = (!r && load) ? model_grant(n, m_ptr[inst], rq) : -1;
        eack = (g >= 0) ? 4'(1 << g) : 4'b0;
        #1;
        last_ack = (inst == 0) ? ack4 : {1'b0, ack3};
        chk("ack", inst, 32'(last_ack), 32'(eack));
        @(posedge clk);
        if (r) begin
            model_reset(inst);
        end else if (load) begin
            if (g >= 0) begin
                m_sel[inst]   = g;
                m_data[inst]  = int'((d >> (g * 4)) & 16'hF);
                m_valid[inst] = 1'b1;
                m_ptr[inst]   = (g + 1) % n;
            end else begin
                m_valid[inst] = 1'b0;
            end
        end
        #1;
        if (inst == 0) begin
            chk("out_valid", 0, 32'(ov4), 32'(m_valid[0]));
            chk("sel",       0, 32'(sel4), m_sel[0]);
            chk("out_data",  0, 32'(od4), m_data[0]);
        end else begin
            chk("out_valid", 1, 32'(ov3), 32'(m_valid[1]));
            chk("sel",       1, 32'(sel3), m_sel[1]);
            chk("out_data",  1, 32'(od3), m_data[1]);
        end
        @(negedge clk);
    endtask

    int exp_sel4[5]  = '{0, 1, 2, 3, 0};
    int exp_dat4[5]  = '{1, 2, 3, 4, 1};
    int exp_ack4[5]  = '{1, 2, 4, 8, 1};
    int exp_sel3[4]  = '{0, 1, 2, 0};

    initial begin
        model_reset(0);
        model_reset(1);
        last_ack = '0;
        @(negedge clk);

        // Reset with all lanes requesting.
        cyc(0, 1'b1, 4'hF, 16'h4321, 1'b1);
        cyc(0, 1'b1, 4'hF, 16'h4321, 1'b1);
        chk("lit_rst_valid", 0, 32'(ov4), 0);
        chk("lit_rst_sel",   0, 32'(sel4), 0);
        chk("lit_rst_data",  0, 32'(od4), 0);

        // Round robin with all lanes requesting.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b0, 4'hF, 16'h4321, 1'b1);
            chk("lit_rr_ack",  0, 32'(last_ack), exp_ack4[i]);
            chk("lit_rr_sel",  0, 32'(sel4), exp_sel4[i]);
            chk("lit_rr_data", 0, 32'(od4), exp_dat4[i]);
        end

        // Lane 1 is granted next; then apply backpressure for 3 cycles.
        cyc(0, 1'b0, 4'hF, 16'h4321, 1'b1);
        chk("lit_bp_sel_pre", 0, 32'(sel4), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b0, 4'hF, 16'h4321, 1'b0);
            chk("lit_bp_ack",  0, 32'(last_ack), 0);
            chk("lit_bp_sel",  0, 32'(sel4), 1);
            chk("lit_bp_data", 0, 32'(od4), 2);
        end
        cyc(0, 1'b0, 4'hF, 16'h4321, 1'b1);
        chk("lit_bp_release_ack", 0, 32'(last_ack), 4'b0100);
        chk("lit_bp_release_sel", 0, 32'(sel4), 2);

        // Wrap and skip: the pointer is now 3 and only lanes 0 and 1 request.
        cyc(0, 1'b0, 4'b0011, 16'h4321, 1'b1);
        chk("lit_wrap_sel0", 0, 32'(sel4), 0);
        cyc(0, 1'b0, 4'b0011, 16'h4321, 1'b1);
        chk("lit_wrap_sel1", 0, 32'(sel4), 1);

        // Single lane request from lane 2 carrying data 0xA.
        cyc(0, 1'b0, 4'b0100, 16'h0A00, 1'b1);
        chk("lit_single_ack",  0, 32'(last_ack), 4'b0100);
        chk("lit_single_sel",  0, 32'(sel4), 2);
        chk("lit_single_data", 0, 32'(od4), 4'hA);
        cyc(0, 1'b0, 4'b0000, 16'h0000, 1'b1);
        chk("lit_idle_valid", 0, 32'(ov4), 0);
        chk("lit_idle_sel",   0, 32'(sel4), 2);
        cyc(0, 1'b0, 4'hF, 16'h4321, 1'b1);
        chk("lit_after_single_sel", 0, 32'(sel4), 3);

        // Randomized traffic on the N=4 instance.
        for (int i = 0; i < 400; i++) begin
            cyc(0, ($urandom_range(0, 39) == 0), 4'($urandom), 16'($urandom),
                ($urandom_range(0, 3) != 0));
        end
        rst4 = 1'b1;

        // N=3 instance: reset, then round robin with all lanes requesting.
        cyc(1, 1'b1, 4'h7, 16'h0321, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1'b0, 4'h7, 16'h0321, 1'b1);
            chk("lit_n3_sel", 1, 32'(sel3), exp_sel3[i]);
        end
        cyc(1, 1'b0, 4'h7, 16'h0321, 1'b1);
        cyc(1, 1'b0, 4'h7, 16'h0321, 1'b1);
        chk("lit_n3_sel2", 1, 32'(sel3), 2);
        cyc(1, 1'b0, 4'h7, 16'h0321, 1'b0);
        chk("lit_n3_stall_sel", 1, 32'(sel3), 2);

        // Reset while stalled: the held word is dropped.
        cyc(1, 1'b1, 4'h7, 16'h0321, 1'b0);
        chk("lit_n3_rst_valid", 1, 32'(ov3), 0);
        chk("lit_n3_rst_ack",   1, 32'(last_ack), 0);
        cyc(1, 1'b0, 4'h7, 16'h0321, 1'b1);
        chk("lit_n3_post_rst_ack", 1, 32'(last_ack), 3'b001);
        chk("lit_n3_post_rst_sel", 1, 32'(sel3), 0);

        // Randomized traffic on the N=3 instance.
        for (int i = 0; i < 300; i++) begin
            cyc(1, ($urandom_range(0, 39) == 0), 4'($urandom), 16'($urandom),
                ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
